// File: rtl/ccs_pkg.sv
// ccs_pkg: shared state, response-code and command types for the CCS
// single-register access engine and the sensor sequencers that feed it.
package ccs_pkg;

    typedef enum logic [2:0] {
        CCS_IDLE    = 3'd0,
        CCS_ISSUE   = 3'd1,
        CCS_REG_LSB = 3'd2,
        CCS_DATA    = 3'd3,
        CCS_LAST    = 3'd4,
        CCS_RESP    = 3'd5
    } ccs_reg_state_t;

    localparam logic [1:0] CCS_OK       = 2'd0;
    localparam logic [1:0] CCS_NACK     = 2'd1;
    localparam logic [1:0] CCS_ADDR_ERR = 2'd2;
    localparam logic [1:0] CCS_TIMEOUT  = 2'd3;

    // 25-bit command word, laid out so sensor ROM tables can store it directly.
    typedef struct packed {
        logic        read;
        logic [15:0] regAddr;
        logic [7:0]  data;
    } ccs_cmd_t;

    // Builds the 8-bit bus address from the sensor address and the R/W bit.
    function automatic logic [7:0] ccsBusAddress(input logic [7:0] devAddr, input logic readBit);
        return {devAddr[7:1], readBit};
    endfunction

endpackage

// File: rtl/ccs_timeout_counter.sv
// ccs_timeout_counter: counts cycles spent waiting on the i2c master and
// flags expiry when the count reaches TIMEOUT_CYCLES-1.
module ccs_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk_in,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] r_count;

    // Count while enabled, holding at the limit; any clear restarts from zero.
    always_ff @(posedge clk_in) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_expired = i_enable && (r_count == LIMIT);

endmodule

// File: rtl/ccs_reg_access.sv
// ccs_reg_access: runs one 16-bit-address sensor register write or read on
// the shared i2c_master per command and returns one response.
// Optional NACK retry is compiled in with the macro CCS_REG_RETRY_EN.
module ccs_reg_access
    import ccs_pkg::*;
#(
    parameter logic [7:0] DEVICE_ADDRESS = 8'h6c,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter int         MAX_RETRIES    = 3
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_read,
    input  logic [15:0] cmd_reg,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic [1:0]  rsp_err,
    output logic        busy,
    output logic [7:0]  i2c_address,
    output logic        i2c_transfer_start,
    output logic        i2c_transfer_continues,
    output logic [7:0]  i2c_data_tx,
    input  logic        i2c_transfer_ready,
    input  logic        i2c_interrupt,
    input  logic        i2c_nack,
    input  logic        i2c_address_err,
    input  logic [7:0]  i2c_data_rx
);

    localparam logic [7:0] WR_ADDRESS = ccsBusAddress(DEVICE_ADDRESS, 1'b0);
    localparam logic [7:0] RD_ADDRESS = ccsBusAddress(DEVICE_ADDRESS, 1'b1);

    ccs_reg_state_t r_state, w_nextState;
    ccs_cmd_t       r_cmd, w_cmdNext;
    logic           r_start, w_startNext;
    logic           r_cont, w_contNext;
    logic [7:0]     r_addr, w_addrNext;
    logic [7:0]     r_dataTx, w_dataTxNext;
    logic [7:0]     r_rspData, w_rspDataNext;
    logic [1:0]     r_rspErr, w_rspErrNext;
    logic           w_timeoutExpired;
    logic           w_waitState;
    logic           w_stateChange;
    logic           w_busError;

`ifdef CCS_REG_RETRY_EN
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);
    logic [RETRY_W-1:0] r_retryCount, w_retryNext;
`else
    logic w_unusedRetries;
    assign w_unusedRetries = (MAX_RETRIES != 0);
`endif

    assign w_waitState   = (r_state == CCS_ISSUE) || (r_state == CCS_REG_LSB) ||
                           (r_state == CCS_DATA)  || (r_state == CCS_LAST);
    assign w_stateChange = (w_nextState != r_state);
    // A NACK only counts while writing; the master NACKs the last read byte itself.
    assign w_busError    = i2c_address_err || (i2c_nack && !r_addr[0]);

    ccs_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_in   (clk_in),
        .reset    (reset),
        .i_clear  (w_stateChange),
        .i_enable (w_waitState),
        .o_expired(w_timeoutExpired)
    );

    // State register: reset returns straight to IDLE without a response.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state <= CCS_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and next bus/response values; interrupts beat timeout expiry.
    always_comb begin
        w_nextState   = r_state;
        w_cmdNext     = r_cmd;
        w_startNext   = r_start;
        w_contNext    = r_cont;
        w_addrNext    = r_addr;
        w_dataTxNext  = r_dataTx;
        w_rspDataNext = r_rspData;
        w_rspErrNext  = r_rspErr;
`ifdef CCS_REG_RETRY_EN
        w_retryNext   = r_retryCount;
`endif
        case (r_state)
            CCS_IDLE: begin
`ifdef CCS_REG_RETRY_EN
                w_retryNext = '0;
`endif
                if (cmd_valid) begin
                    w_cmdNext   = '{read: cmd_read, regAddr: cmd_reg, data: cmd_data};
                    w_nextState = CCS_ISSUE;
                end
            end
            CCS_ISSUE: begin
                if (i2c_transfer_ready) begin
                    w_startNext  = 1'b1;
                    w_contNext   = 1'b1;
                    w_addrNext   = WR_ADDRESS;
                    w_dataTxNext = r_cmd.regAddr[15:8];
                    w_nextState  = CCS_REG_LSB;
                end else if (w_timeoutExpired) begin
                    w_startNext   = 1'b0;
                    w_contNext    = 1'b0;
                    w_rspDataNext = 8'h00;
                    w_rspErrNext  = CCS_TIMEOUT;
                    w_nextState   = CCS_RESP;
                end
            end
            CCS_REG_LSB, CCS_DATA, CCS_LAST: begin
                if (i2c_interrupt) begin
                    if (w_busError) begin
                        w_startNext   = 1'b0;
                        w_contNext    = 1'b0;
                        w_rspDataNext = 8'h00;
                        w_rspErrNext  = i2c_address_err ? CCS_ADDR_ERR : CCS_NACK;
                        w_nextState   = CCS_RESP;
`ifdef CCS_REG_RETRY_EN
                        if (!i2c_address_err && (r_retryCount < RETRY_LIMIT)) begin
                            w_retryNext = r_retryCount + RETRY_W'(1);
                            w_nextState = CCS_ISSUE;
                        end
`endif
                    end else begin
                        case (r_state)
                            CCS_REG_LSB: begin
                                w_startNext  = 1'b0;
                                w_contNext   = !r_cmd.read;
                                w_dataTxNext = r_cmd.regAddr[7:0];
                                w_nextState  = CCS_DATA;
                            end
                            CCS_DATA: begin
                                w_startNext  = r_cmd.read;
                                w_contNext   = 1'b0;
                                w_dataTxNext = r_cmd.data;
                                if (r_cmd.read) begin
                                    w_addrNext = RD_ADDRESS;
                                end
                                w_nextState  = CCS_LAST;
                            end
                            default: begin
                                w_startNext   = 1'b0;
                                w_contNext    = 1'b0;
                                w_rspDataNext = r_cmd.read ? i2c_data_rx : 8'h00;
                                w_rspErrNext  = CCS_OK;
                                w_nextState   = CCS_RESP;
                            end
                        endcase
                    end
                end else if (w_timeoutExpired) begin
                    w_startNext   = 1'b0;
                    w_contNext    = 1'b0;
                    w_rspDataNext = 8'h00;
                    w_rspErrNext  = CCS_TIMEOUT;
                    w_nextState   = CCS_RESP;
                end
            end
            CCS_RESP: begin
                if (rsp_ready) begin
                    w_nextState = CCS_IDLE;
                end
            end
            default: begin
                w_nextState = CCS_IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded straight from the state.
    always_comb begin
        cmd_ready = (r_state == CCS_IDLE);
        busy      = (r_state != CCS_IDLE);
        rsp_valid = (r_state == CCS_RESP);
    end

    // Registered command, bus drive and response values.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_cmd     <= '0;
            r_start   <= 1'b0;
            r_cont    <= 1'b0;
            r_addr    <= WR_ADDRESS;
            r_dataTx  <= 8'h00;
            r_rspData <= 8'h00;
            r_rspErr  <= CCS_OK;
        end else begin
            r_cmd     <= w_cmdNext;
            r_start   <= w_startNext;
            r_cont    <= w_contNext;
            r_addr    <= w_addrNext;
            r_dataTx  <= w_dataTxNext;
            r_rspData <= w_rspDataNext;
            r_rspErr  <= w_rspErrNext;
        end
    end

`ifdef CCS_REG_RETRY_EN
    // NACK retry counter, cleared whenever the engine is idle.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_retryCount <= '0;
        end else begin
            r_retryCount <= w_retryNext;
        end
    end
`endif

    assign i2c_address            = r_addr;
    assign i2c_transfer_start     = r_start;
    assign i2c_transfer_continues = r_cont;
    assign i2c_data_tx            = r_dataTx;
    assign rsp_data               = r_rspData;
    assign rsp_err                = r_rspErr;

endmodule

// File: tb/tb_ccs_reg_access.sv
// tb_ccs_reg_access: directed and randomized register commands against a
// behavioural model of the byte sequence and the response each command earns.
module tb_ccs_reg_access;

    localparam int TB_TIMEOUT     = 100;
    localparam int TB_MAX_RETRIES = 3;
`ifdef CCS_REG_RETRY_EN
    localparam int NACK_ATTEMPTS  = TB_MAX_RETRIES + 1;
`else
    localparam int NACK_ATTEMPTS  = 1;
`endif
    localparam int FAULT_NONE = 0;
    localparam int FAULT_NACK = 1;
    localparam int FAULT_AERR = 2;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_read;
    logic [15:0] cmd_reg;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_err;
    logic        busy;
    logic [7:0]  i2c_address;
    logic        i2c_transfer_start;
    logic        i2c_transfer_continues;
    logic [7:0]  i2c_data_tx;
    logic        i2c_transfer_ready;
    logic        i2c_interrupt;
    logic        i2c_nack;
    logic        i2c_address_err;
    logic [7:0]  i2c_data_rx;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_in = ~clk_in;

    ccs_reg_access #(
        .DEVICE_ADDRESS(8'h6c),
        .TIMEOUT_CYCLES(TB_TIMEOUT),
        .MAX_RETRIES   (TB_MAX_RETRIES)
    ) dut (
        .clk_in                (clk_in),
        .reset                 (reset),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_read              (cmd_read),
        .cmd_reg               (cmd_reg),
        .cmd_data              (cmd_data),
        .rsp_valid             (rsp_valid),
        .rsp_ready             (rsp_ready),
        .rsp_data              (rsp_data),
        .rsp_err               (rsp_err),
        .busy                  (busy),
        .i2c_address           (i2c_address),
        .i2c_transfer_start    (i2c_transfer_start),
        .i2c_transfer_continues(i2c_transfer_continues),
        .i2c_data_tx           (i2c_data_tx),
        .i2c_transfer_ready    (i2c_transfer_ready),
        .i2c_interrupt         (i2c_interrupt),
        .i2c_nack              (i2c_nack),
        .i2c_address_err       (i2c_address_err),
        .i2c_data_rx           (i2c_data_rx)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".cmdReady"}, cmd_ready, 1);
        checkOutput({tag, ".rspValid"}, rsp_valid, 0);
        checkOutput({tag, ".rspData"}, rsp_data, 0);
        checkOutput({tag, ".rspErr"}, rsp_err, 0);
        checkOutput({tag, ".busy"}, busy, 0);
        checkOutput({tag, ".start"}, i2c_transfer_start, 0);
        checkOutput({tag, ".cont"}, i2c_transfer_continues, 0);
        checkOutput({tag, ".dataTx"}, i2c_data_tx, 0);
        checkOutput({tag, ".address"}, i2c_address, 8'h6c);
    endtask

    // Offer one command; the master side becomes ready after readyDelay cycles.
    task automatic applyStimulus(input logic read, input logic [15:0] regAddr, input logic [7:0] data,
                                 input int readyDelay);
        cmd_valid          = 1'b1;
        cmd_read           = read;
        cmd_reg            = regAddr;
        cmd_data           = data;
        i2c_transfer_ready = 1'b0;
        checkOutput("cmdReadyIdle", cmd_ready, 1);
        @(negedge clk_in);
        cmd_valid = 1'b0;
        cmd_read  = 1'($urandom_range(0, 1));
        cmd_reg   = 16'($urandom);
        cmd_data  = 8'($urandom);
        checkOutput("busyAfterAccept", busy, 1);
        checkOutput("cmdReadyBusy", cmd_ready, 0);
        repeat (readyDelay) @(negedge clk_in);
        i2c_transfer_ready = 1'b1;
    endtask

    task automatic waitStart(input string tag);
        int n;
        n = 0;
        while (i2c_transfer_start !== 1'b1 && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        checkOutput(tag, i2c_transfer_start, 1);
    endtask

    // Expected master-side view while byte k is in flight.
    task automatic checkByte(input int k, input logic read, input logic [15:0] regAddr, input logic [7:0] data);
        logic [7:0] expAddr;
        logic       expStart;
        logic       expCont;
        logic [7:0] expTx;
        expAddr  = (k == 2 && read) ? 8'h6d : 8'h6c;
        expStart = (k == 0) || (k == 2 && read);
        expCont  = (k == 0) || (k == 1 && !read);
        expTx    = (k == 0) ? regAddr[15:8] : (k == 1) ? regAddr[7:0] : data;
        checkOutput($sformatf("byte%0d.address", k), i2c_address, expAddr);
        checkOutput($sformatf("byte%0d.start", k), i2c_transfer_start, expStart);
        checkOutput($sformatf("byte%0d.cont", k), i2c_transfer_continues, expCont);
        checkOutput($sformatf("byte%0d.dataTx", k), i2c_data_tx, expTx);
    endtask

    task automatic pulseInterrupt(input logic nack, input logic aerr, input logic [7:0] rx);
        i2c_interrupt   = 1'b1;
        i2c_nack        = nack;
        i2c_address_err = aerr;
        i2c_data_rx     = rx;
        @(negedge clk_in);
        i2c_interrupt   = 1'b0;
        i2c_nack        = 1'b0;
        i2c_address_err = 1'b0;
        i2c_data_rx     = ~rx;
    endtask

    // One pass over the three bytes; stops at the first byte the slave rejects.
    task automatic runAttempt(input logic read, input logic [15:0] regAddr, input logic [7:0] data,
                              input int faultKind, input int faultByte, input logic [7:0] rx);
        logic faulted;
        logic nack;
        logic aerr;
        faulted = 1'b0;
        for (int k = 0; k < 3 && !faulted; k++) begin
            checkByte(k, read, regAddr, data);
            repeat ($urandom_range(0, 2)) @(negedge clk_in);
            nack    = (faultKind == FAULT_NACK && faultByte == k) || (read && k == 2);
            aerr    = (faultKind == FAULT_AERR && faultByte == k);
            faulted = aerr || (nack && !(read && k == 2));
            pulseInterrupt(nack, aerr, (k == 2) ? rx : ~rx);
        end
    endtask

    // Hold the response for holdCycles, then accept it.
    task automatic releaseResponse(input int holdCycles, input logic [7:0] expData);
        rsp_ready = 1'b0;
        for (int h = 0; h < holdCycles; h++) begin
            cmd_valid = 1'b1;
            @(negedge clk_in);
            checkOutput("hold.rspValid", rsp_valid, 1);
            checkOutput("hold.rspData", rsp_data, expData);
            checkOutput("hold.cmdReady", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk_in);
        rsp_ready = 1'b0;
        checkOutput("release.rspValid", rsp_valid, 0);
        checkOutput("release.cmdReady", cmd_ready, 1);
        checkOutput("release.busy", busy, 0);
    endtask

    // Full command with the model's expected attempts and response.
    task automatic runCommand(input logic read, input logic [15:0] regAddr, input logic [7:0] data,
                              input int faultKind, input int faultByte, input logic [7:0] rx,
                              input int holdCycles);
        logic       effectiveNack;
        int         expAttempts;
        logic [1:0] expErr;
        logic [7:0] expData;
        effectiveNack = (faultKind == FAULT_NACK) && !(read && faultByte == 2);
        expAttempts   = effectiveNack ? NACK_ATTEMPTS : 1;
        expErr        = (faultKind == FAULT_AERR) ? 2'd2 : effectiveNack ? 2'd1 : 2'd0;
        expData       = (expErr == 2'd0 && read) ? rx : 8'h00;
        applyStimulus(read, regAddr, data, $urandom_range(0, 3));
        for (int a = 0; a < expAttempts; a++) begin
            waitStart($sformatf("attempt%0d.start", a));
            runAttempt(read, regAddr, data, faultKind, faultByte, rx);
            checkOutput($sformatf("attempt%0d.rspValid", a), rsp_valid, (a == expAttempts - 1));
        end
        checkOutput("rsp.err", rsp_err, expErr);
        checkOutput("rsp.data", rsp_data, expData);
        checkOutput("rsp.start", i2c_transfer_start, 0);
        checkOutput("rsp.cont", i2c_transfer_continues, 0);
        releaseResponse(holdCycles, expData);
    endtask

    initial begin
        int cycles;
        int kind;
        reset              = 1'b1;
        cmd_valid          = 1'b0;
        cmd_read           = 1'b0;
        cmd_reg            = 16'h0000;
        cmd_data           = 8'h00;
        rsp_ready          = 1'b0;
        i2c_transfer_ready = 1'b1;
        i2c_interrupt      = 1'b0;
        i2c_nack           = 1'b0;
        i2c_address_err    = 1'b0;
        i2c_data_rx        = 8'h00;
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        checkResetState("reset");

        $display("[TB] write 0x0100 <= 0x01");
        runCommand(1'b0, 16'h0100, 8'h01, FAULT_NONE, 0, 8'h00, 1);

        $display("[TB] read 0x300a returns 0x56");
        runCommand(1'b1, 16'h300a, 8'h00, FAULT_NONE, 0, 8'h56, 0);

        $display("[TB] write 0x3034 with NACK on register LSB");
        runCommand(1'b0, 16'h3034, 8'h08, FAULT_NACK, 1, 8'h00, 0);

        $display("[TB] address error on first byte");
        runCommand(1'b0, 16'h1234, 8'h55, FAULT_AERR, 0, 8'h00, 0);

        $display("[TB] timeout with no interrupt");
        applyStimulus(1'b0, 16'h4000, 8'h11, 0);
        waitStart("timeout.start");
        cycles = 0;
        while (rsp_valid !== 1'b1 && cycles < 3 * TB_TIMEOUT) begin
            @(negedge clk_in);
            cycles++;
        end
        checkOutput("timeout.cycles", cycles, TB_TIMEOUT);
        checkOutput("timeout.rspErr", rsp_err, 3);
        checkOutput("timeout.rspData", rsp_data, 0);
        checkOutput("timeout.start", i2c_transfer_start, 0);
        releaseResponse(0, 8'h00);

        $display("[TB] reset while in DATA");
        applyStimulus(1'b0, 16'h0202, 8'h33, 0);
        waitStart("midReset.start");
        checkByte(0, 1'b0, 16'h0202, 8'h33);
        pulseInterrupt(1'b0, 1'b0, 8'h00);
        checkByte(1, 1'b0, 16'h0202, 8'h33);
        reset = 1'b1;
        @(negedge clk_in);
        reset = 1'b0;
        checkResetState("midReset");
        repeat (4) begin
            @(negedge clk_in);
            checkOutput("midReset.noRsp", rsp_valid, 0);
        end

        $display("[TB] response held by consumer");
        runCommand(1'b1, 16'h0016, 8'h00, FAULT_NONE, 0, 8'ha5, 6);

        $display("[TB] randomized commands");
        for (int i = 0; i < 24; i++) begin
            kind = $urandom_range(0, 9);
            runCommand(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                       (kind < 6) ? FAULT_NONE : (kind < 8) ? FAULT_NACK : FAULT_AERR,
                       $urandom_range(0, 2), 8'($urandom), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
